mic1_mem_if: RTL and testbench
==============================

Name: mic1_mem_if

Overview:
- Memory-interface stage between the MIC-1 datapath (MAR/MDR/PC/MBR) and the dual-port main memory.
- Registers the microinstruction's rd/wr/fetch requests and drives the memory port controls.
- Captures read data into MDR/MBR with the fixed MIC-1 timing: a request issued in cycle k yields data usable in cycle k+2.
- Flags illegal or out-of-range accesses.

Parameters:
- MEMORY_SIZE, 'h0083, memory depth in 32-bit words; the legal word address range is 0..MEMORY_SIZE-1.
- RESET_VAL, 32'h0, reset value of mdr_o and mbru_o/mbr_o.

Ports:
- clk  in  1  system clock; rising edge for this block, memory samples on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_i  in  1  word read request at MAR (microinstruction bit).
- wr_i  in  1  word write request of mdr_i to MAR.
- fetch_i  in  1  byte fetch request at PC.
- mar_i  in  32  word address.
- mdr_i  in  32  write data.
- pc_i  in  32  byte address.
- wen_A  out  1  memory port A write enable.
- ren_A  out  1  memory port A read enable.
- ren_B  out  1  memory port B read enable.
- addr_A  out  32  port A word address.
- wdata_A  out  32  port A write data.
- addr_B  out  32  port B byte address.
- rdata_A  in  32  port A read data.
- rdata_B  in  8  port B byte (lane already selected by memory).
- mdr_o  out  32  MDR value loaded from memory.
- mdr_load_o  out  1  one-cycle pulse: mdr_o updated this cycle.
- mbr_o  out  32  MBR sign-extended byte.
- mbru_o  out  32  MBR zero-extended byte.
- mbr_load_o  out  1  one-cycle pulse: mbr_o/mbru_o updated.
- err_o  out  1  sticky access-error flag.
- err_clr_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wen_A, ren_A, ren_B, mdr_load_o, mbr_load_o and err_o go to 0.
  - addr_A, addr_B and wdata_A go to 0.
  - mdr_o, mbr_o and mbru_o go to RESET_VAL.
  - All in-flight requests are discarded; no load pulse follows release of reset.
- Stage S1 (issue), at the rising edge ending cycle k:
  - The block samples rd_i/wr_i/fetch_i, mar_i, mdr_i and pc_i.
  - During cycle k+1 it drives ren_A/wen_A/ren_B with registered addresses and data.
  - The memory acts on the falling edge inside cycle k+1.
- Stage S2 (capture), at the rising edge ending cycle k+1:
  - A read latches rdata_A into mdr_o and asserts mdr_load_o for cycle k+2.
  - A fetch latches rdata_B; mbr_o = {{24{b[7]}},b} and mbru_o = {24'h0,b}; mbr_load_o is asserted for cycle k+2.
- Outputs hold their last loaded value until the next load.
- Controls are registered with a one-cycle pulse per request; an idle cycle drives all enables to 0.
- addr_A and addr_B hold their last values when idle; addr_B must stay stable through cycle k+1 for the memory's lane select.
- Pipelining: a new request is accepted every cycle. Back-to-back rd at cycles k and k+1 gives loads at k+2 and k+3. No stall output.
- rd and fetch in the same cycle are legal and independent (separate ports).
- wr and fetch in the same cycle are legal.
- rd and wr in the same cycle are illegal:
  - The write proceeds and the read is dropped (no ren_A, no mdr_load_o).
  - err_o is set.
- Read-after-write:
  - A wr at cycle k followed by an rd to the same address at k+1 returns the new data, because the write completes at the falling edge of k+1, before the read's falling edge at k+2.
  - An rd issued in the same cycle as wr is the illegal case above.
- Range check at S1:
  - rd/wr: an access with mar_i >= MEMORY_SIZE is suppressed (no enable, no load pulse) and sets err_o.
  - fetch: an access with (pc_i >> 2) >= MEMORY_SIZE is suppressed in the same way and sets err_o.
  - Legal requests in the same cycle on the other port still proceed.
- err_o:
  - Set-dominant: if err_clr_i and a new error occur in the same cycle, err_o stays 1.
  - err_o is cleared only by err_clr_i or reset.
- Addresses are unsigned 32-bit; there is no wrap-around; MAR is a word address and PC is a byte address.
- Reset asserted mid-operation (between S1 and S2):
  - The pending capture is cancelled.
  - Outputs go to reset values immediately.
  - A write already driven may or may not complete in memory; the bench must not check that location.

Test Plan:
- Write then read: wr mar=5, mdr=32'hCAFEF00D at k; rd mar=5 at k+1 -> wen_A pulse at k+1; mdr_o=32'hCAFEF00D with mdr_load_o=1 in cycle k+3.
- Fetch sign/zero extension: memory word 2 = 32'h80FF7F01; fetch pc=8,9,10,11 on consecutive cycles:
  - mbru_o sequence is 32'h01, 32'h7F, 32'hFF, 32'h80.
  - mbr_o sequence is 32'h01, 32'h7F, 32'hFFFFFFFF, 32'hFFFFFF80.
  - Loads land in cycles k+2..k+5.
- Concurrent ports: rd mar=3 plus fetch pc=0 in the same cycle -> both load pulses two cycles later with correct independent data.
- Illegal combination: rd and wr both at mar=4 -> memory written, no mdr_load_o, err_o=1 until err_clr_i, then 0 next cycle.
- Out of range (MEMORY_SIZE='h83): rd mar=32'h83 -> no ren_A, err_o=1; fetch pc=32'h20C -> no ren_B, err_o=1; mar=32'h82 -> normal read.
- Reset mid-read: rd at k, rst_n low during k+1 -> mdr_o=RESET_VAL, no mdr_load_o after release; a subsequent read works normally.

Source files
------------

// File: rtl/mic1_mem_if.sv
// MIC-1 memory interface: registers rd/wr/fetch requests onto the dual-port memory
// and captures read data into MDR/MBR two cycles after issue.
module mic1_mem_if #(
  parameter logic [31:0] MEMORY_SIZE = 32'h0000_0083,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic        fetch_i,
  input  logic [31:0] mar_i,
  input  logic [31:0] mdr_i,
  input  logic [31:0] pc_i,
  output logic        wen_A,
  output logic        ren_A,
  output logic        ren_B,
  output logic [31:0] addr_A,
  output logic [31:0] wdata_A,
  output logic [31:0] addr_B,
  input  logic [31:0] rdata_A,
  input  logic [7:0]  rdata_B,
  output logic [31:0] mdr_o,
  output logic        mdr_load_o,
  output logic [31:0] mbr_o,
  output logic [31:0] mbru_o,
  output logic        mbr_load_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  logic mar_ok, pc_ok;
  logic rd_ok, wr_ok, fetch_ok;
  logic err_set, err_d;

  always_comb begin
    mar_ok   = mar_i < MEMORY_SIZE;
    pc_ok    = (pc_i >> 2) < MEMORY_SIZE;
    // A simultaneous rd+wr lets the write win and drops the read.
    wr_ok    = wr_i && mar_ok;
    rd_ok    = rd_i && !wr_i && mar_ok;
    fetch_ok = fetch_i && pc_ok;
    err_set  = (rd_i && wr_i) || ((rd_i || wr_i) && !mar_ok) || (fetch_i && !pc_ok);
    err_d    = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_o);
  end

  // Issue stage: one-cycle enables; addresses/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_A   <= 1'b0;
      ren_A   <= 1'b0;
      ren_B   <= 1'b0;
      addr_A  <= 32'h0;
      wdata_A <= 32'h0;
      addr_B  <= 32'h0;
      err_o   <= 1'b0;
    end else begin
      wen_A <= wr_ok;
      ren_A <= rd_ok;
      ren_B <= fetch_ok;
      if (rd_ok || wr_ok) addr_A <= mar_i;
      if (wr_ok) wdata_A <= mdr_i;
      if (fetch_ok) addr_B <= pc_i;
      err_o <= err_d;
    end
  end

  // Capture stage: memory has answered on the falling edge of the enable cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdr_o      <= RESET_VAL;
      mdr_load_o <= 1'b0;
      mbr_o      <= RESET_VAL;
      mbru_o     <= RESET_VAL;
      mbr_load_o <= 1'b0;
    end else begin
      mdr_load_o <= ren_A;
      mbr_load_o <= ren_B;
      if (ren_A) mdr_o <= rdata_A;
      if (ren_B) begin
        mbr_o  <= {{24{rdata_B[7]}}, rdata_B};
        mbru_o <= {24'h0, rdata_B};
      end
    end
  end

endmodule

// File: tb/tb_mic1_mem_if.sv
// Bench for mic1_mem_if: behavioural dual-port memory, a per-cycle expectation
// model built from request order, and directed vectors with literal checks.
module tb_mic1_mem_if;
  localparam int MSIZE = 'h83;

  logic        clk, rst_n;
  logic        rd_i, wr_i, fetch_i, err_clr_i;
  logic [31:0] mar_i, mdr_i, pc_i;
  logic        wen_A, ren_A, ren_B;
  logic [31:0] addr_A, wdata_A, addr_B, rdata_A;
  logic [7:0]  rdata_B;
  logic [31:0] mdr_o, mbr_o, mbru_o;
  logic        mdr_load_o, mbr_load_o, err_o;

  mic1_mem_if #(.MEMORY_SIZE(32'h83), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rd_i(rd_i), .wr_i(wr_i), .fetch_i(fetch_i),
    .mar_i(mar_i), .mdr_i(mdr_i), .pc_i(pc_i), .wen_A(wen_A), .ren_A(ren_A),
    .ren_B(ren_B), .addr_A(addr_A), .wdata_A(wdata_A), .addr_B(addr_B),
    .rdata_A(rdata_A), .rdata_B(rdata_B), .mdr_o(mdr_o), .mdr_load_o(mdr_load_o),
    .mbr_o(mbr_o), .mbru_o(mbru_o), .mbr_load_o(mbr_load_o), .err_o(err_o),
    .err_clr_i(err_clr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: acts on the falling edge, little-endian byte lanes on port B.
  logic [31:0] mem [MSIZE];
  logic [31:0] ref_mem [MSIZE];

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 2) ? 32'h80FF7F01 : {b, 8'hA5, b, 8'h3C};
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    int sh;
    if (wen_A && addr_A < MSIZE) mem[int'(addr_A)] = wdata_A;
    if (ren_A && addr_A < MSIZE) rdata_A = mem[int'(addr_A)];
    if (ren_B && (addr_B >> 2) < MSIZE) begin
      w = mem[int'(addr_B >> 2)];
      sh = 8 * int'(addr_B[1:0]);
      rdata_B = 8'(w >> sh);
    end
  end

  // Expectation model: each accepted request schedules its effects by cycle number.
  localparam int NCYC = 1024;
  int          cyc = 0;
  logic        ld_mdr [NCYC];
  logic        ld_mbr [NCYC];
  logic [31:0] v_mdr  [NCYC];
  logic [7:0]  v_mbr  [NCYC];
  logic        e_wen, e_ren, e_renb, e_err;
  logic [31:0] e_addr_A, e_wdata, e_addr_B, e_mdr;
  logic [7:0]  e_byte;

  task automatic model_reset();
    for (int i = 0; i < NCYC; i++) begin
      ld_mdr[i] = 1'b0;
      ld_mbr[i] = 1'b0;
    end
    {e_wen, e_ren, e_renb, e_err} = '0;
    e_addr_A = 0; e_wdata = 0; e_addr_B = 0; e_mdr = 0; e_byte = 0;
  endtask

  always @(posedge clk) begin
    int k;
    logic m_ok, p_ok;
    k = cyc;
    if (!rst_n) begin
      model_reset();
    end else if (k + 2 < NCYC) begin
      m_ok   = mar_i < MSIZE;
      p_ok   = (pc_i >> 2) < MSIZE;
      e_wen  = wr_i && m_ok;
      e_ren  = rd_i && !wr_i && m_ok;
      e_renb = fetch_i && p_ok;
      if (e_wen) begin
        ref_mem[int'(mar_i)] = mdr_i;
        e_wdata = mdr_i;
      end
      if (e_wen || e_ren) e_addr_A = mar_i;
      if (e_ren) begin
        ld_mdr[k + 2] = 1'b1;
        v_mdr[k + 2]  = ref_mem[int'(mar_i)];
      end
      if (e_renb) begin
        ld_mbr[k + 2] = 1'b1;
        v_mbr[k + 2]  = 8'(ref_mem[int'(pc_i >> 2)] >> (8 * int'(pc_i[1:0])));
        e_addr_B = pc_i;
      end
      if ((rd_i && wr_i) || ((rd_i || wr_i) && !m_ok) || (fetch_i && !p_ok)) e_err = 1'b1;
      else if (err_clr_i) e_err = 1'b0;
    end
    cyc = k + 1;
    if (cyc < NCYC) begin
      if (ld_mdr[cyc]) e_mdr = v_mdr[cyc];
      if (ld_mbr[cyc]) e_byte = v_mbr[cyc];
    end
  end

  always @(posedge clk) begin
    #4;
    if (!rst_n) begin
      chk("rst_wen_A", {31'h0, wen_A}, 0);
      chk("rst_ren_A", {31'h0, ren_A}, 0);
      chk("rst_ren_B", {31'h0, ren_B}, 0);
      chk("rst_addr_A", addr_A, 0);
      chk("rst_addr_B", addr_B, 0);
      chk("rst_wdata_A", wdata_A, 0);
      chk("rst_mdr_o", mdr_o, 0);
      chk("rst_mbr_o", mbr_o, 0);
      chk("rst_mbru_o", mbru_o, 0);
      chk("rst_loads", {30'h0, mdr_load_o, mbr_load_o}, 0);
      chk("rst_err_o", {31'h0, err_o}, 0);
    end else if (cyc < NCYC) begin
      chk("wen_A", {31'h0, wen_A}, {31'h0, e_wen});
      chk("ren_A", {31'h0, ren_A}, {31'h0, e_ren});
      chk("ren_B", {31'h0, ren_B}, {31'h0, e_renb});
      chk("addr_A", addr_A, e_addr_A);
      chk("addr_B", addr_B, e_addr_B);
      if (e_wen) chk("wdata_A", wdata_A, e_wdata);
      chk("mdr_load_o", {31'h0, mdr_load_o}, {31'h0, ld_mdr[cyc]});
      chk("mbr_load_o", {31'h0, mbr_load_o}, {31'h0, ld_mbr[cyc]});
      chk("mdr_o", mdr_o, e_mdr);
      chk("mbru_o", mbru_o, {24'h0, e_byte});
      chk("mbr_o", mbr_o, {{24{e_byte[7]}}, e_byte});
      chk("err_o", {31'h0, err_o}, {31'h0, e_err});
    end
  end

  task automatic issue(input logic r, input logic w, input logic f, input logic [31:0] mar,
                       input logic [31:0] md, input logic [31:0] pc, input logic clr);
    rd_i = r; wr_i = w; fetch_i = f; mar_i = mar; mdr_i = md; pc_i = pc; err_clr_i = clr;
    @(posedge clk);
    #2;
    rd_i = 0; wr_i = 0; fetch_i = 0; err_clr_i = 0;
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < MSIZE; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    rdata_A = 0; rdata_B = 0;
    rst_n = 0; rd_i = 0; wr_i = 0; fetch_i = 0; err_clr_i = 0;
    mar_i = 0; mdr_i = 0; pc_i = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    idle();

    // Write then read-after-write
    issue(0, 1, 0, 5, 32'hCAFEF00D, 0, 0);
    chk("raw_wen", {31'h0, wen_A}, 1);
    issue(1, 0, 0, 5, 0, 0, 0);
    idle();
    chk("raw_load", {31'h0, mdr_load_o}, 1);
    chk("raw_mdr", mdr_o, 32'hCAFEF00D);

    // Byte fetches with sign/zero extension
    issue(0, 0, 1, 0, 0, 8, 0);
    issue(0, 0, 1, 0, 0, 9, 0);
    chk("f8_mbru", mbru_o, 32'h01);
    chk("f8_mbr", mbr_o, 32'h01);
    issue(0, 0, 1, 0, 0, 10, 0);
    chk("f9_mbru", mbru_o, 32'h7F);
    chk("f9_mbr", mbr_o, 32'h7F);
    issue(0, 0, 1, 0, 0, 11, 0);
    chk("f10_mbru", mbru_o, 32'hFF);
    chk("f10_mbr", mbr_o, 32'hFFFFFFFF);
    idle();
    chk("f11_mbru", mbru_o, 32'h80);
    chk("f11_mbr", mbr_o, 32'hFFFFFF80);
    chk("f11_load", {31'h0, mbr_load_o}, 1);

    // Concurrent rd + fetch
    issue(1, 0, 1, 3, 0, 0, 0);
    idle();
    chk("cc_loads", {30'h0, mdr_load_o, mbr_load_o}, 32'h3);
    chk("cc_mdr", mdr_o, 32'h03A5033C);
    chk("cc_mbru", mbru_o, 32'h3C);

    // Illegal rd+wr: write wins, read dropped, sticky error
    issue(1, 1, 0, 4, 32'hDEADBEEF, 0, 0);
    chk("ill_wen", {31'h0, wen_A}, 1);
    chk("ill_ren", {31'h0, ren_A}, 0);
    chk("ill_err", {31'h0, err_o}, 1);
    idle();
    chk("ill_noload", {31'h0, mdr_load_o}, 0);
    issue(1, 0, 0, 4, 0, 0, 0);
    idle();
    chk("ill_mem", mdr_o, 32'hDEADBEEF);
    chk("ill_sticky", {31'h0, err_o}, 1);
    issue(0, 0, 0, 0, 0, 0, 1);
    chk("ill_clr", {31'h0, err_o}, 0);

    // Range checks
    issue(1, 0, 0, 32'h83, 0, 0, 0);
    chk("oor_rd_ren", {31'h0, ren_A}, 0);
    chk("oor_rd_err", {31'h0, err_o}, 1);
    issue(0, 0, 0, 0, 0, 0, 1);
    chk("oor_clr", {31'h0, err_o}, 0);
    issue(0, 0, 1, 0, 0, 32'h20C, 0);
    chk("oor_f_ren", {31'h0, ren_B}, 0);
    chk("oor_f_err", {31'h0, err_o}, 1);
    issue(1, 0, 0, 32'h83, 0, 0, 1);
    chk("set_dominant", {31'h0, err_o}, 1);
    issue(0, 0, 0, 0, 0, 0, 1);
    issue(1, 0, 0, 32'h82, 0, 0, 0);
    chk("edge_ren", {31'h0, ren_A}, 1);
    chk("edge_addr", addr_A, 32'h82);
    idle();
    chk("edge_mdr", mdr_o, 32'h82A5823C);
    chk("edge_err", {31'h0, err_o}, 0);

    // Reset between issue and capture
    issue(1, 0, 0, 7, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("mr_mdr", mdr_o, 0);
    chk("mr_ren", {31'h0, ren_A}, 0);
    @(posedge clk);
    #2 rst_n = 1;
    chk("mr_noload", {31'h0, mdr_load_o}, 0);
    idle();
    chk("mr_noload2", {31'h0, mdr_load_o}, 0);
    chk("mr_mdr2", mdr_o, 0);
    issue(1, 0, 0, 7, 0, 0, 0);
    idle();
    chk("mr_after", mdr_o, 32'h07A5073C);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
